// File: rtl/freq_bcd_formatter.sv
// Binary-to-BCD formatter for the frequency meter display: iterative double-dabble
// (one bit per clock), auto-ranging to Hz or kHz, and a leading-zero blank mask.
module freq_bcd_formatter #(
  parameter int unsigned IN_WIDTH   = 32,
  parameter logic [7:0]  KHZ_DP_SEL = 8'b0000_0010
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic [IN_WIDTH-1:0] BinIn,
  input  logic                BinValid,
  output logic                Busy,
  output logic                Done,
  output logic [31:0]         BcdOut,
  output logic [7:0]          DpSel,
  output logic                Range,
  output logic [7:0]          BlankMask
);

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    FMT
  } state_t;

  localparam logic [5:0] CNT_LAST = 6'(IN_WIDTH - 1);

  state_t              state;
  logic [IN_WIDTH-1:0] shift;
  logic [39:0]         bcd;
  logic [39:0]         bcd_adj;
  logic [5:0]          cnt;

  logic [31:0]         fmt_bcd;
  logic [7:0]          fmt_dp;
  logic                fmt_range;
  logic [7:0]          fmt_blank;
  logic                lead;

  // Add-3 correction applied to every digit before the shift.
  always_comb begin
    bcd_adj = bcd;
    for (int unsigned d = 0; d < 10; d++) begin
      if (bcd[d*4 +: 4] >= 4'd5) begin
        bcd_adj[d*4 +: 4] = bcd[d*4 +: 4] + 4'd3;
      end
    end
  end

  // kHz range keeps D9..D2 (truncating D1, D0); blank mask tracks the shown digits.
  always_comb begin
    fmt_range = |bcd[39:32];
    fmt_bcd   = fmt_range ? bcd[39:8] : bcd[31:0];
    fmt_dp    = fmt_range ? KHZ_DP_SEL : '0;
    fmt_blank = '0;
    lead      = 1'b1;
    for (int unsigned k = 0; k < 7; k++) begin
      lead               = lead & (fmt_bcd[(7-k)*4 +: 4] == 4'd0);
      fmt_blank[7-k]     = lead;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= IDLE;
      shift     <= '0;
      bcd       <= '0;
      cnt       <= '0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      BcdOut    <= '0;
      DpSel     <= '0;
      Range     <= 1'b0;
      BlankMask <= 8'b1111_1110;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (BinValid) begin
            shift <= BinIn;
            bcd   <= '0;
            cnt   <= '0;
            Busy  <= 1'b1;
            state <= CONV;
          end
        end
        CONV: begin
          bcd   <= {bcd_adj[38:0], shift[IN_WIDTH-1]};
          shift <= shift << 1;
          cnt   <= cnt + 6'd1;
          if (cnt == CNT_LAST) begin
            state <= FMT;
          end
        end
        FMT: begin
          BcdOut    <= fmt_bcd;
          DpSel     <= fmt_dp;
          Range     <= fmt_range;
          BlankMask <= fmt_blank;
          Done      <= 1'b1;
          Busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_freq_bcd_formatter.sv
// Scoreboard bench for freq_bcd_formatter: expected results are queued at acceptance
// and compared whenever Done pulses; latency and Busy length are checked per request.
module tb_freq_bcd_formatter;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic [31:0] BinIn = '0;
  logic        BinValid = 1'b0;
  logic        Busy;
  logic        Done;
  logic [31:0] BcdOut;
  logic [7:0]  DpSel;
  logic        Range;
  logic [7:0]  BlankMask;

  typedef struct {
    logic [31:0] bcd;
    logic [7:0]  dp;
    logic        rng;
    logic [7:0]  blank;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   errors  = 0;

  freq_bcd_formatter #(
    .IN_WIDTH(32),
    .KHZ_DP_SEL(8'b0000_0010)
  ) dut (
    .Clk(Clk),
    .Rst(Rst),
    .BinIn(BinIn),
    .BinValid(BinValid),
    .Busy(Busy),
    .Done(Done),
    .BcdOut(BcdOut),
    .DpSel(DpSel),
    .Range(Range),
    .BlankMask(BlankMask)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Decimal model by repeated division; blank mask from the shown digit count.
  function automatic exp_t model(input logic [31:0] v);
    exp_t            e;
    logic [39:0]     b;
    longint unsigned x;
    longint unsigned disp;
    int              nd;
    logic [7:0]      m;
    x = longint'(v);
    b = '0;
    for (int d = 0; d < 10; d++) begin
      b[d*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    e.rng = (v >= 32'd100000000);
    e.bcd = e.rng ? b[39:8] : b[31:0];
    e.dp  = e.rng ? 8'b0000_0010 : 8'b0000_0000;
    disp  = e.rng ? longint'(v) / 100 : longint'(v);
    nd    = 1;
    while (disp >= 10) begin
      disp = disp / 10;
      nd++;
    end
    m = 8'hFF;
    m = m << nd;
    e.blank = m;
    return e;
  endfunction

  always @(negedge Clk) begin
    if (Done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("bcd", 64'(BcdOut), 64'(e.bcd));
        chk("dp", 64'(DpSel), 64'(e.dp));
        chk("range", 64'(Range), 64'(e.rng));
        chk("blank", 64'(BlankMask), 64'(e.blank));
      end
    end
  end

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic wait_done;
    int lat;
    int bcount;
    lat    = 0;
    bcount = 1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (Done) begin
        lat = i;
        break;
      end
      if (Busy) bcount++;
    end
    chk("latency", 64'(lat), 64'd33);
    chk("busy_len", 64'(bcount), 64'd33);
    chk("busy_after_done", 64'(Busy), 64'd0);
  endtask

  task automatic convert(input logic [31:0] v);
    BinIn    = v;
    BinValid = 1'b1;
    tick();
    BinValid = 1'b0;
    sb.push_back(model(v));
    chk("busy_accept", 64'(Busy), 64'd1);
    wait_done();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, 64'(Busy), 64'd0);
    chk({tag, "_done"}, 64'(Done), 64'd0);
    chk({tag, "_bcd"}, 64'(BcdOut), 64'd0);
    chk({tag, "_dp"}, 64'(DpSel), 64'd0);
    chk({tag, "_range"}, 64'(Range), 64'd0);
    chk({tag, "_blank"}, 64'(BlankMask), 64'hFE);
  endtask

  initial begin
    tick();
    tick();
    Rst = 1'b0;
    chk_reset_vals("rst");

    convert(32'd0);
    convert(32'd12345678);
    convert(32'd99999999);
    convert(32'd100000000);
    convert(32'hFFFF_FFFF);

    // Requests during CONV and at the FMT edge are dropped; E34 is accepted.
    BinIn    = 32'd763;
    BinValid = 1'b1;
    tick();
    sb.push_back(model(32'd763));
    BinValid = 1'b0;
    repeat (4) tick();
    BinIn    = 32'd1526;
    BinValid = 1'b1;
    tick();
    BinValid = 1'b0;
    repeat (27) tick();
    BinValid = 1'b1;
    chk("pre_fmt_done", 64'(Done), 64'd0);
    tick();
    chk("fmt_done", 64'(Done), 64'd1);
    chk("fmt_busy", 64'(Busy), 64'd0);
    tick();
    BinValid = 1'b0;
    sb.push_back(model(32'd1526));
    chk("e34_accept", 64'(Busy), 64'd1);
    wait_done();

    // Reset mid-conversion aborts without Done.
    BinIn    = 32'd3051;
    BinValid = 1'b1;
    tick();
    BinValid = 1'b0;
    sb.push_back(model(32'd3051));
    repeat (9) tick();
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    void'(sb.pop_back());
    chk_reset_vals("abort");
    tick();
    chk("abort_idle_done", 64'(Done), 64'd0);
    convert(32'd3051);

    for (int r = 0; r < 6; r++) begin
      convert($urandom);
    end
    convert(32'd1000);
    convert(32'd7);

    repeat (3) tick();
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
